load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage load/store unit that sits directly upstream of the byte-addressed data memory.
//  It turns CPU load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses on the data memory.
//  Loads: lane extraction plus sign/zero extension. Sub-word stores: read-modify-write, so neighbouring bytes are preserved.
//  Misaligned accesses are flagged and never reach the memory.
// PARAMETERS
//  SIZE  32  data/address width; the memory word is 4 bytes, little-endian
// PORTS
//  clk           in   1     clock; all state updates on posedge
//  rst           in   1     synchronous, active-high reset
//  req_valid     in   1     request present
//  req_ready     out  1     unit idle, can accept a request
//  req_we        in   1     1 = store, 0 = load
//  req_size      in   2     00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1     loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr      in   SIZE  byte address
//  req_wdata     in   SIZE  store data, right-justified
//  resp_valid    out  1     one-cycle completion pulse
//  resp_rdata    out  SIZE  load result; 0 for stores and errors
//  resp_err      out  1     misaligned or reserved size; valid with resp_valid
//  mem_addr      out  SIZE  word-aligned address to data memory
//  mem_wdata     out  SIZE  full word to data memory
//  mem_rdata     in   SIZE  data-memory read port; registered, valid 1 cycle after mem_read
//  mem_read      out  1     data-memory read strobe
//  mem_write     out  1     data-memory write strobe; memory writes on the same edge
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0 while rst=1; resp_valid=0, resp_err=0, resp_rdata=0.
//   Also mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. After reset, req_ready=1.
//  Accept: request accepted on an edge where req_valid & req_ready.
//   All req_* fields are latched at acceptance; inputs are ignored while busy.
//  req_ready=1 only in IDLE. No request is accepted in RESP.
//  States: IDLE, RD, CAP, WR, RESP.
//   IDLE -> RESP       on error (no memory access)
//   IDLE -> WR         on SW
//   IDLE -> RD         on any load, SB or SH
//   RD -> CAP
//   CAP -> RESP        on loads
//   CAP -> WR          on SB/SH
//   WR -> RESP
//   RESP -> IDLE
//  RD: mem_read=1, mem_addr={addr[SIZE-1:2],2'b00}.
//  CAP: mem_rdata is valid.
//   Loads: extract the lane and register it into resp_rdata.
//   SB/SH: merge the store lane into the read word and register the result into wbuf.
//  WR: mem_write=1, mem_addr=aligned address.
//   mem_wdata = req_wdata for SW, wbuf for SB/SH.
//  RESP: resp_valid=1 for exactly one cycle; resp_rdata and resp_err are held.
//   resp_rdata and resp_err return to 0 in IDLE.
//  Lane mapping: byte k (k=addr[1:0]) = word[8k+7:8k].
//   Half at addr[1]=0 is [15:0]; half at addr[1]=1 is [31:16].
//  Extension: LB/LH replicate the lane MSB up to SIZE-1; LBU/LHU fill with 0.
//  Error (resp_err=1): half with addr[0]=1; word with addr[1:0]!=0; req_size=11.
//   On error, mem_read/mem_write stay 0 for the whole transaction.
//  Latency from the acceptance edge (cycle 0) to resp_valid:
//   error 1, SW 2, loads 3, SB/SH 4.
//  mem_read and mem_write are never high in the same cycle; each is high at most 1 cycle per transaction.
//  Outside RD/WR, mem_read=mem_write=0 and mem_addr holds its last value.
//  Address bits above the memory depth are passed through unmodified; the memory wraps them.
//  Reset mid-operation: the next state is IDLE and the transaction is dropped with no resp_valid.
//   If rst=1 during WR, the memory write on that edge is committed.
//   In any earlier state the memory is untouched.
// TESTING
//  1 SW 0x807FFF01? no: SW 0x80FF7F01 @4, then
//    LB @5 -> 0x0000007F; LB @6 -> 0xFFFFFFFF; LBU @6 -> 0x000000FF;
//    LH @6 -> 0xFFFF80FF; LHU @6 -> 0x000080FF; LW @4 -> 0x80FF7F01.
//  2 SW 0x11223344 @8, SB 0x000000AB @9 -> mem_write once, 3 cycles after acceptance,
//    with mem_wdata=0x1122AB44 and resp_valid at cycle 4; then LW @8 -> 0x1122AB44.
//  3 SH 0x0000BEEF @10 on that word -> LW @8 = 0xBEEFAB44; SH @9 -> resp_err=1, memory unchanged.
//  4 LW @2, LH @3, req_size=11 @0 -> resp_err=1 at cycle 1,
//    resp_rdata=0, mem_read/mem_write never asserted.
//  5 rst=1 during CAP of SB @9 -> no mem_write, no resp_valid,
//    req_ready=1 the cycle after rst drops, LW @8 unchanged.
//  6 req_valid held high with 3 queued requests -> each accepted only with req_ready=1;
//    measured latencies are LW 3 and SW 2 with one idle cycle between;
//    req_* changes while busy have no effect.

Source files
------------

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : MEM-stage load/store unit in front of a byte-addressed,
//                word-wide data memory. Loads extract a lane and extend it;
//                sub-word stores use read-modify-write. Misaligned accesses
//                and the reserved size are reported and never reach memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            resp_valid,
    output logic [SIZE-1:0] resp_rdata,
    output logic            resp_err,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_wdata,
    input  logic [SIZE-1:0] mem_rdata,
    output logic            mem_read,
    output logic            mem_write
);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    // Fields latched at acceptance
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [1:0]      r_off;
    logic [SIZE-1:0] r_wdata;

    // Registered outputs
    logic [SIZE-1:0] r_mem_addr;
    logic [SIZE-1:0] r_wbuf;
    logic [SIZE-1:0] r_rdata;
    logic            r_err;

    logic            w_ready;
    logic            w_accept;
    logic            w_req_err;
    logic            w_req_sw;
    logic [4:0]      w_shamt;
    logic [SIZE-1:0] w_lane;
    logic [SIZE-1:0] w_load_data;
    logic [SIZE-1:0] w_lane_mask;
    logic [SIZE-1:0] w_mask;
    logic [SIZE-1:0] w_wdata_sh;
    logic [SIZE-1:0] w_merged;

    assign w_ready   = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && w_ready;
    assign w_req_err = (req_size == c_SZ_RSVD)
                     || ((req_size == c_SZ_HALF) && req_addr[0])
                     || ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_req_sw  = req_we && (req_size == c_SZ_WORD);

    // Lane k lives at bits [8k+7:8k]; shift it down to bit 0 for loads and
    // shift store data up into it for merges.
    assign w_shamt     = {r_off, 3'b000};
    assign w_lane      = mem_rdata >> w_shamt;
    assign w_lane_mask = (r_size == c_SZ_BYTE) ? {{(SIZE-8){1'b0}}, 8'hFF}
                                               : {{(SIZE-16){1'b0}}, 16'hFFFF};
    assign w_mask      = w_lane_mask << w_shamt;
    assign w_wdata_sh  = r_wdata << w_shamt;
    assign w_merged    = (mem_rdata & ~w_mask) | (w_wdata_sh & w_mask);

    // Load result: pick the lane and sign- or zero-extend it
    always_comb begin
        w_load_data = w_lane;
        case (r_size)
            c_SZ_BYTE: w_load_data = r_uns ? {{(SIZE-8){1'b0}}, w_lane[7:0]}
                                           : {{(SIZE-8){w_lane[7]}}, w_lane[7:0]};
            c_SZ_HALF: w_load_data = r_uns ? {{(SIZE-16){1'b0}}, w_lane[15:0]}
                                           : {{(SIZE-16){w_lane[15]}}, w_lane[15:0]};
            default:   w_load_data = w_lane;
        endcase
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)     w_next_state = S_RESP;
                    else if (w_req_sw) w_next_state = S_WR;
                    else               w_next_state = S_RD;
                end
            end
            S_RD:    w_next_state = S_CAP;
            S_CAP:   w_next_state = r_we ? S_WR : S_RESP;
            S_WR:    w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset drops any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Request latching, memory address/data and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            r_off      <= 2'b00;
            r_wdata    <= '0;
            r_mem_addr <= '0;
            r_wbuf     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_off   <= req_addr[1:0];
                r_wdata <= req_wdata;
                r_rdata <= '0;
                r_err   <= w_req_err;
                // Erroring requests leave the memory address untouched
                if (!w_req_err)
                    r_mem_addr <= {req_addr[SIZE-1:2], 2'b00};
                if (w_req_sw)
                    r_wbuf <= req_wdata;
            end
            if (r_state == S_CAP) begin
                if (r_we) r_wbuf  <= w_merged;
                else      r_rdata <= w_load_data;
            end
            if (r_state == S_RESP) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign req_ready  = w_ready;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_wbuf;
    assign mem_read   = (r_state == S_RD);
    assign mem_write  = (r_state == S_WR);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a registered
//                word memory model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    // Registered-read data memory; writes commit on the strobe edge
    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= mem[mem_addr[9:2]];
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    load_store_unit #(.SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write)
    );

    // Issue one request and observe it until resp_valid (bounded)
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] o_rdata, output logic o_err,
                          output int o_lat, output int o_nrd, output int o_nwr,
                          output int o_wrcyc, output logic [31:0] o_wrdata,
                          output logic [31:0] o_wraddr, output logic o_both);
        int  n;
        bit  done;
        o_rdata = '0; o_err = 1'b0; o_lat = -1; o_nrd = 0; o_nwr = 0;
        o_wrcyc = -1; o_wrdata = '0; o_wraddr = '0; o_both = 1'b0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (mem_read) o_nrd++;
            if (mem_write) begin
                o_nwr++; o_wrcyc = c; o_wrdata = mem_wdata; o_wraddr = mem_addr;
            end
            if (mem_read && mem_write) o_both = 1'b1;
            if (resp_valid) begin
                o_lat = c; o_rdata = resp_rdata; o_err = resp_err; done = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: resp_valid never seen for addr %08h (got none, required within 20 cycles)", addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", req_ready); end
        checks++;
        if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0000", {resp_valid, resp_err, mem_read, mem_write});
        end
        checks++;
        if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %08h/%08h/%08h required 0/0/0", resp_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", req_ready); end
    endtask

    // Word store then every load flavour across the lanes, then a byte RMW
    task automatic test_loads();
        logic        t_we  [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  t_sz  [11] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2};
        logic        t_uns [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_ad  [11] = '{32'd4, 32'd5, 32'd6, 32'd6, 32'd6, 32'd6, 32'd4, 32'd7, 32'd4, 32'd4, 32'd4};
        logic [31:0] t_wd  [11] = '{32'h80FF7F01, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h12345666, 32'h0};
        logic [31:0] t_exp [11] = '{32'h0, 32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
                                    32'h000080FF, 32'h00007F01, 32'hFFFFFF80, 32'h80FF7F01, 32'h0, 32'h80FF7F66};
        int          t_lat [11] = '{2, 3, 3, 3, 3, 3, 3, 3, 3, 4, 3};
        logic [31:0] rd, wd, wa;
        logic        er, both;
        int          lat, nr, nw, wc, exp_nr, exp_nw;
        exp_t        e;
        for (int i = 0; i < 11; i++) begin
            e.rdata = t_exp[i]; e.err = 1'b0;
            sb_q.push_back(e);
            exp_nr = (t_we[i] && t_sz[i] == 2'd2) ? 0 : 1;
            exp_nw = t_we[i] ? 1 : 0;
            do_req(t_we[i], t_sz[i], t_uns[i], t_ad[i], t_wd[i], rd, er, lat, nr, nw, wc, wd, wa, both);
            e = sb_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err) begin
                errors++; $display("FAIL load[%0d] data: got %08h err %b required %08h err %b", i, rd, er, e.rdata, e.err);
            end
            checks++;
            if (lat !== t_lat[i]) begin errors++; $display("FAIL load[%0d] latency: got %0d required %0d", i, lat, t_lat[i]); end
            checks++;
            if (nr !== exp_nr || nw !== exp_nw || both !== 1'b0) begin
                errors++; $display("FAIL load[%0d] strobes: got rd %0d wr %0d both %b required rd %0d wr %0d both 0", i, nr, nw, both, exp_nr, exp_nw);
            end
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd, wd, wa;
        logic        er, both;
        int          lat, nr, nw, wc;
        exp_t        e;
        e = '{32'h0, 1'b0}; sb_q.push_back(e);
        do_req(1'b1, 2'd2, 1'b0, 32'd8, 32'h11223344, rd, er, lat, nr, nw, wc, wd, wa, both);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat !== 2) begin
            errors++; $display("FAIL sw8: got %08h err %b lat %0d required %08h err %b lat 2", rd, er, lat, e.rdata, e.err);
        end
        // SB @9: one read, write 3 cycles after acceptance, response at 4
        e = '{32'h0, 1'b0}; sb_q.push_back(e);
        do_req(1'b1, 2'd0, 1'b0, 32'd9, 32'h000000AB, rd, er, lat, nr, nw, wc, wd, wa, both);
        e = sb_q.pop_front();
        checks++;
        if (nw !== 1 || wc !== 3 || wd !== 32'h1122AB44 || wa !== 32'd8) begin
            errors++; $display("FAIL sb9 write: got n %0d cyc %0d data %08h addr %08h required 1 3 1122ab44 00000008", nw, wc, wd, wa);
        end
        checks++;
        if (rd !== e.rdata || er !== e.err || lat !== 4 || nr !== 1 || both !== 1'b0) begin
            errors++; $display("FAIL sb9 resp: got %08h err %b lat %0d rd %0d both %b required %08h %b 4 1 0", rd, er, lat, nr, both, e.rdata, e.err);
        end
        e = '{32'h1122AB44, 1'b0}; sb_q.push_back(e);
        do_req(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, er, lat, nr, nw, wc, wd, wa, both);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL lw8_after_sb: got %08h required %08h", rd, e.rdata); end
        // SH @10 updates the upper half
        e = '{32'h0, 1'b0}; sb_q.push_back(e);
        do_req(1'b1, 2'd1, 1'b0, 32'd10, 32'h0000BEEF, rd, er, lat, nr, nw, wc, wd, wa, both);
        e = sb_q.pop_front();
        checks++;
        if (wd !== 32'hBEEFAB44 || lat !== 4 || er !== e.err || rd !== e.rdata) begin
            errors++; $display("FAIL sh10: got data %08h lat %0d err %b required beefab44 4 0", wd, lat, er);
        end
        // SH @9 is misaligned and must not touch memory
        e = '{32'h0, 1'b1}; sb_q.push_back(e);
        do_req(1'b1, 2'd1, 1'b0, 32'd9, 32'h00001234, rd, er, lat, nr, nw, wc, wd, wa, both);
        e = sb_q.pop_front();
        checks++;
        if (er !== e.err || rd !== e.rdata || lat !== 1 || nr !== 0 || nw !== 0) begin
            errors++; $display("FAIL sh9_err: got err %b data %08h lat %0d rd %0d wr %0d required 1 0 1 0 0", er, rd, lat, nr, nw);
        end
        e = '{32'hBEEFAB44, 1'b0}; sb_q.push_back(e);
        do_req(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, er, lat, nr, nw, wc, wd, wa, both);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL lw8_after_sh: got %08h required %08h", rd, e.rdata); end
    endtask

    task automatic test_errors();
        logic        t_we  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  t_sz  [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
        logic [31:0] t_ad  [5] = '{32'd2, 32'd3, 32'd0, 32'd6, 32'd5};
        logic [31:0] rd, wd, wa;
        logic        er, both;
        int          lat, nr, nw, wc;
        exp_t        e;
        for (int i = 0; i < 5; i++) begin
            e = '{32'h0, 1'b1}; sb_q.push_back(e);
            do_req(t_we[i], t_sz[i], 1'b0, t_ad[i], 32'hDEADBEEF, rd, er, lat, nr, nw, wc, wd, wa, both);
            e = sb_q.pop_front();
            checks++;
            if (er !== e.err || rd !== e.rdata || lat !== 1) begin
                errors++; $display("FAIL err[%0d] resp: got err %b data %08h lat %0d required 1 00000000 1", i, er, rd, lat);
            end
            checks++;
            if (nr !== 0 || nw !== 0) begin
                errors++; $display("FAIL err[%0d] strobes: got rd %0d wr %0d required 0 0", i, nr, nw);
            end
        end
        e = '{32'h80FF7F66, 1'b0}; sb_q.push_back(e);
        do_req(1'b0, 2'd2, 1'b0, 32'd4, 32'h0, rd, er, lat, nr, nw, wc, wd, wa, both);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL lw4_after_err: got %08h required %08h", rd, e.rdata); end
    endtask

    // Abort during CAP must not write; abort during WR must still commit
    task automatic test_reset_mid_op();
        logic [31:0] rd, wd, wa;
        logic        er, both;
        int          lat, nr, nw, wc, n;
        exp_t        e;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            @(negedge clk);
            while (!req_ready && n < 20) begin @(negedge clk); n++; end
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
            req_addr = (k == 0) ? 32'd9 : 32'd8;
            req_wdata = (k == 0) ? 32'h00000077 : 32'h000000CD;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_read !== 1'b1) begin errors++; $display("FAIL rstmid[%0d] rd_phase: got %b required 1", k, mem_read); end
            @(negedge clk);
            if (k == 1) @(negedge clk);
            checks++;
            if (mem_write !== k[0]) begin errors++; $display("FAIL rstmid[%0d] wr_phase: got %b required %b", k, mem_write, k[0]); end
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL rstmid[%0d] in_reset: got v %b w %b rdy %b required 0 0 0", k, resp_valid, mem_write, req_ready);
            end
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                errors++; $display("FAIL rstmid[%0d] after: got rdy %b v %b required 1 0", k, req_ready, resp_valid);
            end
            e.rdata = (k == 0) ? 32'hBEEFAB44 : 32'hBEEFABCD; e.err = 1'b0;
            sb_q.push_back(e);
            do_req(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, er, lat, nr, nw, wc, wd, wa, both);
            e = sb_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL rstmid[%0d] lw8: got %08h required %08h", k, rd, e.rdata); end
        end
    endtask

    // req_valid held high over three requests; garbage presented while busy
    task automatic test_back_to_back();
        logic        t_we  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] t_ad  [3] = '{32'd8, 32'd12, 32'd12};
        logic [31:0] t_wd  [3] = '{32'h0, 32'hCAFEF00D, 32'h0};
        logic [31:0] t_exp [3] = '{32'hBEEFABCD, 32'h0, 32'hCAFEF00D};
        int          t_lat [3] = '{3, 2, 3};
        int          acc [3];
        int          rsp [3];
        int          idx, nresp, cyc;
        exp_t        e;
        idx = 0; nresp = 0; cyc = 0;
        @(negedge clk);
        for (int n = 0; n < 60 && nresp < 3; n++) begin
            if (n > 0) @(negedge clk);
            cyc++;
            if (resp_valid) begin
                rsp[nresp] = cyc;
                e = sb_q.pop_front();
                checks++;
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    errors++; $display("FAIL b2b[%0d] data: got %08h err %b required %08h err %b", nresp, resp_rdata, resp_err, e.rdata, e.err);
                end
                nresp++;
            end
            if (idx < 3 && req_ready) begin
                req_valid = 1'b1; req_we = t_we[idx]; req_size = 2'd2; req_unsigned = 1'b0;
                req_addr = t_ad[idx]; req_wdata = t_wd[idx];
                acc[idx] = cyc;
                e.rdata = t_exp[idx]; e.err = 1'b0;
                sb_q.push_back(e);
                idx++;
            end else if (idx < 3) begin
                req_we    = 1'($urandom_range(1, 0));
                req_size  = 2'($urandom_range(3, 0));
                req_addr  = $urandom;
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (nresp !== 3) begin errors++; $display("FAIL b2b count: got %0d responses required 3", nresp); end
        for (int i = 0; i < nresp; i++) begin
            checks++;
            if (rsp[i] - acc[i] !== t_lat[i]) begin
                errors++; $display("FAIL b2b[%0d] latency: got %0d required %0d", i, rsp[i] - acc[i], t_lat[i]);
            end
            if (i > 0) begin
                checks++;
                if (acc[i] !== rsp[i-1] + 1) begin
                    errors++; $display("FAIL b2b[%0d] gap: accepted at %0d required %0d", i, acc[i], rsp[i-1] + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_subword_store();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        checks++;
        if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
